// File: rtl/apb_slave_regbank_if.sv
// apb_slave_regbank_if: APB bus bundle between a requester and the register bank
interface apb_slave_regbank_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;
    modport master (output psel, penable, pwrite, paddr, pwdata, pstrb, input prdata, pready, pslverr);
    modport slave  (input psel, penable, pwrite, paddr, pwdata, pstrb, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_slave_regbank.sv
// apb_slave_regbank: APB completer with fixed wait states, byte-strobed register file and error decode
module apb_slave_regbank #(
    parameter int                   ADDR_WIDTH  = 8,
    parameter int                   DATA_WIDTH  = 32,
    parameter int                   NUM_REGS    = 16,
    parameter int                   WAIT_STATES = 1,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA5B0_0001
) (
    input logic                clk,
    input logic                rst_n,
    apb_slave_regbank_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = $clog2(NUM_REGS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]         strb_q, strb_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [ADDR_WIDTH-3:0] idx;
    logic [IW-1:0]         ridx;
    logic                  err, ready, setup;
    // Decode works only on latched fields so outputs never see the live bus
    assign idx   = addr_q[ADDR_WIDTH-1:2];
    assign ridx  = idx[IW-1:0];
    assign err   = (addr_q[1:0] != 2'b00) || (32'(idx) >= NUM_REGS) || (write_q && idx == '0);
    assign ready = (state_q == ACCESS) && (cnt_q == '0);
    assign setup = bus.psel && !bus.penable;
    assign bus.pready  = ready;
    assign bus.pslverr = ready && err;
    assign bus.prdata  = (ready && !write_q && !err) ? ((ridx == '0) ? ID_VALUE : regs_q[ridx]) : '0;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        regs_d  = regs_q;
        if (setup) begin
            addr_d  = bus.paddr;
            write_d = bus.pwrite;
            wdata_d = bus.pwdata;
            strb_d  = bus.pstrb;
            cnt_d   = WS;
            state_d = ACCESS;
        end else if (state_q == ACCESS) begin
            if (!bus.psel) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                state_d = IDLE;
                if (write_q && !err)
                    for (int b = 0; b < NB; b++)
                        if (strb_q[b]) regs_d[ridx][8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            regs_q  <= regs_d;
        end
    end
endmodule

// File: tb/tb_apb_slave_regbank.sv
// tb_apb_slave_regbank: directed checks on a one-wait-state and a zero-wait-state bank sharing one bus
module tb_apb_slave_regbank;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic        use0 = 1'b0;
    int          total = 0, bad = 0;
    apb_slave_regbank_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) b0 ();
    apb_slave_regbank_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) b1 ();
    assign b0.psel = psel;   assign b1.psel = psel;
    assign b0.penable = penable; assign b1.penable = penable;
    assign b0.pwrite = pwrite; assign b1.pwrite = pwrite;
    assign b0.paddr = paddr; assign b1.paddr = paddr;
    assign b0.pwdata = pwdata; assign b1.pwdata = pwdata;
    assign b0.pstrb = pstrb; assign b1.pstrb = pstrb;
    apb_slave_regbank #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    apb_slave_regbank #(.WAIT_STATES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    wire        rdy  = use0 ? b0.pready  : b1.pready;
    wire        err  = use0 ? b0.pslverr : b1.pslverr;
    wire [31:0] rdat = use0 ? b0.prdata  : b1.prdata;
    always #5 clk = ~clk;
    // Drives one transfer; cyc = access cycle in which pready rose (0 = never within bound)
    task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                        output int cyc, output logic [31:0] rd, output logic e, output logic leak);
        @(negedge clk);
        leak = rdy | err | (|rdat);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
        cyc = 0; rd = '0; e = 1'b0;
        for (int i = 1; i <= 20 && cyc == 0; i++) begin
            @(negedge clk);
            penable = 1'b1;
            if (rdy) begin cyc = i; rd = rdat; e = err; end
            else leak = leak | err | (|rdat);
        end
    endtask
    task automatic idle();
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask
    task automatic test_reset();
        int c; logic [31:0] rd; logic e, l;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            psel = 1'($urandom); penable = 1'($urandom); pwrite = 1'($urandom);
            paddr = 8'($urandom); pwdata = $urandom; pstrb = 4'($urandom);
            total++;
            if ({rdy, err, rdat} !== 34'd0) begin
                bad++; $display("FAIL reset_outputs: got rdy=%b err=%b rdata=%h, want 0 0 0", rdy, err, rdat);
            end
        end
        psel = 1'b0; penable = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        xfer(1'b0, 8'h04, '0, 4'h0, c, rd, e, l);
        total++;
        if (c !== 2 || rd !== 32'h0 || e !== 1'b0 || l !== 1'b0) begin
            bad++; $display("FAIL reset_read04: got cyc=%0d rd=%h err=%b leak=%b, want 2 00000000 0 0", c, rd, e, l);
        end
    endtask
    task automatic test_write();
        int c; logic [31:0] rd; logic e, l;
        xfer(1'b1, 8'h08, 32'hDEAD_BEEF, 4'hF, c, rd, e, l);
        total++;
        if (c !== 2 || e !== 1'b0 || rd !== 32'h0 || l !== 1'b0) begin
            bad++; $display("FAIL write08: got cyc=%0d err=%b rd=%h leak=%b, want 2 0 00000000 0", c, e, rd, l);
        end
        xfer(1'b0, 8'h08, '0, 4'h0, c, rd, e, l);
        total++;
        if (c !== 2 || rd !== 32'hDEAD_BEEF || e !== 1'b0) begin
            bad++; $display("FAIL read08: got cyc=%0d rd=%h err=%b, want 2 deadbeef 0", c, rd, e);
        end
    endtask
    task automatic test_strobe();
        int c; logic [31:0] rd; logic e, l;
        xfer(1'b1, 8'h08, 32'h1122_3344, 4'b0101, c, rd, e, l);
        xfer(1'b0, 8'h08, '0, 4'h0, c, rd, e, l);
        total++;
        if (rd !== 32'hDE22_BE44 || e !== 1'b0) begin
            bad++; $display("FAIL strobe0101: got rd=%h err=%b, want de22be44 0", rd, e);
        end
        xfer(1'b1, 8'h08, 32'hFFFF_FFFF, 4'b0000, c, rd, e, l);
        xfer(1'b0, 8'h08, '0, 4'h0, c, rd, e, l);
        total++;
        if (rd !== 32'hDE22_BE44) begin
            bad++; $display("FAIL strobe0000: got rd=%h, want de22be44", rd);
        end
    endtask
    task automatic test_errors();
        int c; logic [31:0] rd; logic e, l;
        xfer(1'b0, 8'h01, '0, 4'h0, c, rd, e, l);
        total++;
        if (c !== 2 || e !== 1'b1 || rd !== 32'h0) begin
            bad++; $display("FAIL err_misaligned: got cyc=%0d err=%b rd=%h, want 2 1 00000000", c, e, rd);
        end
        xfer(1'b0, 8'h40, '0, 4'h0, c, rd, e, l);
        total++;
        if (c !== 2 || e !== 1'b1 || rd !== 32'h0) begin
            bad++; $display("FAIL err_index16: got cyc=%0d err=%b rd=%h, want 2 1 00000000", c, e, rd);
        end
        xfer(1'b1, 8'h00, 32'h1234_5678, 4'hF, c, rd, e, l);
        total++;
        if (c !== 2 || e !== 1'b1 || rd !== 32'h0) begin
            bad++; $display("FAIL err_write_id: got cyc=%0d err=%b rd=%h, want 2 1 00000000", c, e, rd);
        end
        xfer(1'b0, 8'h00, '0, 4'h0, c, rd, e, l);
        total++;
        if (rd !== 32'hA5B0_0001 || e !== 1'b0) begin
            bad++; $display("FAIL read_id: got rd=%h err=%b, want a5b00001 0", rd, e);
        end
        xfer(1'b0, 8'h3C, '0, 4'h0, c, rd, e, l);
        total++;
        if (rd !== 32'h0 || e !== 1'b0) begin
            bad++; $display("FAIL read_index15: got rd=%h err=%b, want 00000000 0", rd, e);
        end
    endtask
    task automatic test_abort();
        int c; logic [31:0] rd; logic e, l;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h5555_5555; pstrb = 4'hF;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        total++;
        if (rdy !== 1'b0) begin
            bad++; $display("FAIL abort_wait: got pready=%b, want 0", rdy);
        end
        @(negedge clk);
        total++;
        if (rdy !== 1'b0) begin
            bad++; $display("FAIL abort_idle: got pready=%b, want 0", rdy);
        end
        xfer(1'b0, 8'h0C, '0, 4'h0, c, rd, e, l);
        total++;
        if (rd !== 32'h0 || c !== 2) begin
            bad++; $display("FAIL abort_read0C: got rd=%h cyc=%0d, want 00000000 2", rd, c);
        end
    endtask
    task automatic test_back_to_back();
        int c; logic [31:0] rd; logic e, l;
        use0 = 1'b1;
        xfer(1'b1, 8'h10, 32'hCAFE_F00D, 4'hF, c, rd, e, l);
        total++;
        if (c !== 1 || e !== 1'b0 || rd !== 32'h0) begin
            bad++; $display("FAIL b2b_write: got cyc=%0d err=%b rd=%h, want 1 0 00000000", c, e, rd);
        end
        xfer(1'b0, 8'h10, '0, 4'h0, c, rd, e, l);
        total++;
        if (c !== 1 || rd !== 32'hCAFE_F00D || l !== 1'b0) begin
            bad++; $display("FAIL b2b_read: got cyc=%0d rd=%h leak=%b, want 1 cafef00d 0", c, rd, l);
        end
        xfer(1'b0, 8'h08, '0, 4'h0, c, rd, e, l);
        total++;
        if (c !== 1 || rd !== 32'hDE22_BE44) begin
            bad++; $display("FAIL b2b_read08: got cyc=%0d rd=%h, want 1 de22be44", c, rd);
        end
    endtask
    task automatic test_reset_mid();
        int c; logic [31:0] rd; logic e, l;
        use0 = 1'b1;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h14; pwdata = 32'h7777_7777; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        total++;
        if (rdy !== 1'b1) begin
            bad++; $display("FAIL mid_ready: got pready=%b, want 1", rdy);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({rdy, err, rdat} !== 34'd0) begin
            bad++; $display("FAIL mid_reset_out: got rdy=%b err=%b rdata=%h, want 0 0 0", rdy, err, rdat);
        end
        #1 rst_n = 1'b1;
        xfer(1'b0, 8'h14, '0, 4'h0, c, rd, e, l);
        total++;
        if (c !== 1 || rd !== 32'h0) begin
            bad++; $display("FAIL mid_read14: got cyc=%0d rd=%h, want 1 00000000", c, rd);
        end
        xfer(1'b0, 8'h10, '0, 4'h0, c, rd, e, l);
        total++;
        if (rd !== 32'h0) begin
            bad++; $display("FAIL mid_read10: got rd=%h, want 00000000", rd);
        end
        idle();
    endtask
    initial begin
        test_reset();
        test_write();
        test_strobe();
        test_errors();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/apb_slave_regbank.md
# apb_slave_regbank

APB completer (responder) register bank: the far end of the APB channels the bus router fans out on its four output ports. It decodes a setup/access transfer, inserts a fixed number of wait states, commits writes with byte strobes into a small register file, and returns read data with an error flag. One instance sits behind each router output; the verification bench also uses it as a reference responder.

## Interface

- ADDR_WIDTH, 8, byte-address width of paddr
- DATA_WIDTH, 32, data width; fixed at 32, byte lanes = 4
- NUM_REGS, 16, number of 32-bit registers, index 0 read-only ID
- WAIT_STATES, 1, extra access-phase cycles before pready (0..15)
- ID_VALUE, 32'hA5B0_0001, constant returned by register 0

- clk  in  1  bus clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- psel  in  1  select for this completer
- penable  in  1  access-phase qualifier
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDR_WIDTH  byte address
- pwdata  in  32  write data
- pstrb  in  4  write byte strobes, bit n enables pwdata[8n+7:8n]
- prdata  out  32  read data, valid only when pready=1 and read
- pready  out  1  transfer completes this cycle
- pslverr  out  1  error response, valid only when pready=1

## Operation

- States: IDLE, ACCESS. Reset -> IDLE, wait counter 0, all registers 1..NUM_REGS-1 = 0, latched address/control/data = 0.
- IDLE: rising edge with psel=1, penable=0 (setup) latches paddr, pwrite, pwdata, pstrb; loads counter = WAIT_STATES; -> ACCESS. Any other input: stay IDLE.
- ACCESS, counter != 0: each edge with psel=1, penable=1 decrements counter.
- ACCESS, counter == 0: pready=1. The edge with psel=1, penable=1 completes the transfer: write committed (if legal), -> IDLE.
- Abort: in ACCESS, edge with psel=0 -> IDLE, no write, counter cleared. Edge with psel=1, penable=0 in ACCESS is treated as a new setup (relatch, reload counter), previous transfer dropped.
- Decode: index = paddr[ADDR_WIDTH-1:2]. Error if paddr[1:0] != 0, index >= NUM_REGS, or write to index 0.
- Error transfer: pslverr=1 with pready, no register changes; prdata = 0.
- Legal write: for each set pstrb bit, update that byte of reg[index]; pstrb=0 is legal and changes nothing.
- Legal read: prdata = reg[index] (index 0 returns ID_VALUE); pstrb ignored.
- Outputs decoded from registered state and latched fields only; no combinational path from any input to pready, pslverr, prdata.

## Timing

- Reset values: pready=0, pslverr=0, prdata=0. Reset asserted mid-transfer returns to IDLE immediately, transfer lost, no write.
- Access phase lasts WAIT_STATES+1 cycles; WAIT_STATES=0 gives pready=1 in the first access cycle (zero-wait APB).
- Total transfer = 1 setup + WAIT_STATES+1 access cycles; back-to-back transfers need no idle cycle (setup presented the cycle after completion is accepted from IDLE).
- prdata and pslverr are 0 whenever pready=0; prdata is 0 on write completions.
- Write data visible to a read whose setup follows the completing write edge.

## Test plan

- Reset: hold rst=0, drive random bus -> pready=0, pslverr=0, prdata=0; read addr 0x04 after release -> 0x0000_0000.
- Write 0xDEAD_BEEF to 0x08, pstrb=4'hF, WAIT_STATES=1 -> pready high exactly in second access cycle, pslverr=0; readback 0x08 -> 0xDEAD_BEEF.
- Byte strobes: then write 0x1122_3344 to 0x08 with pstrb=4'b0101 -> readback 0xDE22_BE44.
- Errors: read 0x01 (misaligned), read 0x40 (index 16), write 0x00 -> each pready with pslverr=1, prdata=0; read 0x00 -> 0xA5B0_0001, pslverr=0.
- Abort: setup write 0x0C=0x5555_5555, drop psel in first access cycle -> no pready, readback 0x0C unchanged (0x0000_0000).
- Back-to-back, WAIT_STATES=0: write 0x10, read 0x10 in consecutive setup/access pairs -> pready every second cycle, read returns written value; async rst pulse mid-access -> IDLE, outputs 0 same cycle.
